// File: rtl/parity_pkg.sv
// parity_pkg: shared FSM states, reset values and width helper for parity_accum
package parity_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ACCUM = 2'b01,
        S_DONE  = 2'b10
    } state_t;

    localparam state_t RST_STATE = S_IDLE;
    localparam logic   RST_BIT   = 1'b0;

    // Width needed to hold the values 0..max_words inclusive
    function automatic int cw_f(input int max_words);
        return $clog2(max_words + 1);
    endfunction

endpackage

// File: rtl/parity_accum_xor_word.sv
// xor_word: bitwise XOR of two words plus reduction XOR of the result
module xor_word #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_y,
    output logic             o_par
);

    assign o_y   = i_a ^ i_b;
    assign o_par = ^o_y;

endmodule

// File: rtl/parity_accum.sv
// parity_accum: framed column-XOR parity accumulator; macro PARITY_CHECK_EN adds i_exp_col/o_p_err compare
module parity_accum
    import parity_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  int MAX_WORDS = 16,
    localparam int CW        = cw_f(MAX_WORDS)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [CW-1:0]    i_len,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_d_valid,
`ifdef PARITY_CHECK_EN
    input  logic [WIDTH-1:0] i_exp_col,
    output logic             o_p_err,
`endif
    output logic             o_d_ready,
    output logic [WIDTH-1:0] o_p_col,
    output logic             o_p_bit,
    output logic             o_done,
    output logic             o_busy
);

    localparam logic [CW-1:0] MAX_LEN = CW'(MAX_WORDS);
    localparam logic [CW-1:0] ONE     = CW'(1);

    state_t           r_state;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_p_col;
    logic             r_p_bit;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_len;
    logic [WIDTH-1:0] w_acc_nxt;
    logic             w_acc_par;

    // Next accumulator value and its parity, used both for the update and the final result
    xor_word #(.WIDTH(WIDTH)) u_xor (
        .i_a   (r_acc),
        .i_b   (i_d),
        .o_y   (w_acc_nxt),
        .o_par (w_acc_par)
    );

    assign w_len     = (i_len > MAX_LEN) ? MAX_LEN : i_len;
    assign o_d_ready = (r_state == S_ACCUM);
    assign o_busy    = (r_state == S_ACCUM) || (r_state == S_DONE);
    assign o_done    = (r_state == S_DONE);
    assign o_p_col   = r_p_col;
    assign o_p_bit   = r_p_bit;

`ifdef PARITY_CHECK_EN
    logic r_p_err;
    assign o_p_err = r_p_err;
`endif

    // Frame sequencing, accumulation and result capture on entry to DONE
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= RST_STATE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_p_col <= '0;
            r_p_bit <= RST_BIT;
`ifdef PARITY_CHECK_EN
            r_p_err <= RST_BIT;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_acc <= '0;
                        r_cnt <= w_len;
                        if (i_len == '0) begin
                            r_state <= S_DONE;
                            r_p_col <= '0;
                            r_p_bit <= 1'b0;
`ifdef PARITY_CHECK_EN
                            r_p_err <= |i_exp_col;
`endif
                        end else begin
                            r_state <= S_ACCUM;
                        end
                    end
                end
                S_ACCUM: begin
                    if (i_d_valid) begin
                        r_acc <= w_acc_nxt;
                        r_cnt <= r_cnt - ONE;
                        if (r_cnt == ONE) begin
                            r_state <= S_DONE;
                            r_p_col <= w_acc_nxt;
                            r_p_bit <= w_acc_par;
`ifdef PARITY_CHECK_EN
                            r_p_err <= |(w_acc_nxt ^ i_exp_col);
`endif
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_parity_accum.sv
// tb_parity_accum: scoreboard bench for parity_accum (honours PARITY_CHECK_EN when defined)
module tb_parity_accum;

    localparam int W  = 8;
    localparam int MW = 16;
    localparam int CW = $clog2(MW + 1);

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_start = 1'b0;
    logic          i_d_valid = 1'b0;
    logic [CW-1:0] i_len = '0;
    logic [W-1:0]  i_d = '0;
    logic [W-1:0]  i_exp_col = '0;
    logic          o_d_ready, o_p_bit, o_done, o_busy, o_p_err;
    logic [W-1:0]  o_p_col;

    typedef struct {
        logic [W-1:0] col;
        logic         bt;
        logic         err;
    } exp_t;

    exp_t         q[$];
    exp_t         mon_e;
    int           n_checks = 0;
    int           n_errors = 0;
    logic [W-1:0] last_col = '0;
    logic         last_bit = 1'b0;
    logic         last_err = 1'b0;
    logic [W-1:0] words[32];

    always #5 i_clk = ~i_clk;

    parity_accum #(.WIDTH(W), .MAX_WORDS(MW)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_start   (i_start),
        .i_len     (i_len),
        .i_d       (i_d),
        .i_d_valid (i_d_valid),
`ifdef PARITY_CHECK_EN
        .i_exp_col (i_exp_col),
        .o_p_err   (o_p_err),
`endif
        .o_d_ready (o_d_ready),
        .o_p_col   (o_p_col),
        .o_p_bit   (o_p_bit),
        .o_done    (o_done),
        .o_busy    (o_busy)
    );

`ifndef PARITY_CHECK_EN
    assign o_p_err = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops an expected result on every DONE, otherwise checks that results hold
    always @(negedge i_clk) begin
        if (i_rst) begin
            last_col = '0;
            last_bit = 1'b0;
            last_err = 1'b0;
        end else if (o_done) begin
            if (q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_done: got DONE with empty scoreboard at %0t", $time);
            end else begin
                mon_e = q.pop_front();
                chk("p_col", o_p_col, mon_e.col);
                chk("p_bit", o_p_bit, mon_e.bt);
                chk("done_busy", o_busy, 1);
                chk("done_ready", o_d_ready, 0);
`ifdef PARITY_CHECK_EN
                chk("p_err", o_p_err, mon_e.err);
`endif
                last_col = mon_e.col;
                last_bit = mon_e.bt;
                last_err = mon_e.err;
            end
        end else begin
            chk("p_col_hold", o_p_col, last_col);
            chk("p_bit_hold", o_p_bit, last_bit);
`ifdef PARITY_CHECK_EN
            chk("p_err_hold", o_p_err, last_err);
`endif
        end
    end

    // Reference: result is the XOR of the first min(len, MW) words of the frame
    task automatic run_frame(input int len, input bit hold, input bit rnd,
                             input logic [31:0] vmask, input logic [W-1:0] exp_col);
        int           n;
        int           idx;
        int           cyc;
        bit           v;
        logic [W-1:0] e;
        n = (len > MW) ? MW : len;
        e = '0;
        for (int i = 0; i < n; i++) e ^= words[i];
        q.push_back('{col: e, bt: ^e, err: |(e ^ exp_col)});
        @(negedge i_clk);
        i_start   = 1'b1;
        i_len     = CW'(len);
        i_exp_col = exp_col;
        @(negedge i_clk);
        if (!hold) i_start = 1'b0;
        else i_len = CW'($urandom);
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 300) begin
            chk("ready_accum", o_d_ready, 1);
            chk("busy_accum", o_busy, 1);
            v = rnd ? ($urandom_range(0, 2) != 0) : ((cyc < 32) ? vmask[cyc] : 1'b1);
            i_d_valid = v;
            i_d = v ? words[idx] : W'($urandom);
            @(negedge i_clk);
            if (v) idx++;
            cyc++;
        end
        i_d_valid = 1'b0;
        if (idx < n) begin
            n_checks++;
            n_errors++;
            $display("FAIL frame_timeout: accepted %0d words, required %0d", idx, n);
        end
        chk("done_latency", o_done, 1);
        @(negedge i_clk);
        i_start = 1'b0;
        chk("idle_busy", o_busy, 0);
        chk("idle_ready", o_d_ready, 0);
        chk("idle_done", o_done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge i_clk);
        chk("rst_ready", o_d_ready, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_p_col", o_p_col, 0);
        chk("rst_p_bit", o_p_bit, 0);
        i_rst = 1'b0;

        // Basic back-to-back frame: A5 ^ 3C ^ 0F = 96
        words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'h0F;
        run_frame(3, 1'b0, 1'b0, 32'hFFFF_FFFF, 8'h00);

        // Stalls: valid pattern 1,0,0,1 with FF, 01 gives FE
        words[0] = 8'hFF; words[1] = 8'h01;
        run_frame(2, 1'b0, 1'b0, 32'b1001, 8'hFE);

        // Reset mid-frame after two accepted words
        @(negedge i_clk);
        i_start = 1'b1;
        i_len   = CW'(4);
        @(negedge i_clk);
        i_start   = 1'b0;
        i_d_valid = 1'b1;
        i_d       = 8'h55;
        @(negedge i_clk);
        i_d = 8'h66;
        @(negedge i_clk);
        i_d = 8'h77;
        #2 i_rst = 1'b1;
        #1;
        chk("midrst_ready", o_d_ready, 0);
        chk("midrst_busy", o_busy, 0);
        chk("midrst_done", o_done, 0);
        chk("midrst_p_col", o_p_col, 0);
        chk("midrst_p_bit", o_p_bit, 0);
        i_d_valid = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        repeat (3) begin
            @(negedge i_clk);
            chk("no_done_after_rst", o_done, 0);
        end

        // Zero-length frame
        run_frame(0, 1'b0, 1'b0, 32'hFFFF_FFFF, 8'h00);

        // Over-long frame clamps to MW words
        for (int i = 0; i < 32; i++) words[i] = W'($urandom);
        run_frame(31, 1'b0, 1'b0, 32'hFFFF_FFFF, 8'h00);

        // START held through ACCUM and DONE is ignored
        for (int i = 0; i < 32; i++) words[i] = W'($urandom);
        run_frame(2, 1'b1, 1'b0, 32'hFFFF_FFFF, 8'h00);

        // Expected-column compare
        words[0] = 8'h12; words[1] = 8'h34;
        run_frame(2, 1'b0, 1'b0, 32'hFFFF_FFFF, 8'h26);
        run_frame(2, 1'b0, 1'b0, 32'hFFFF_FFFF, 8'h27);

        // Randomized frames
        repeat (40) begin
            for (int i = 0; i < 32; i++) words[i] = W'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge i_clk);
            run_frame($urandom_range(0, 20), 1'($urandom_range(0, 1)), 1'b1, 32'h0,
                      W'($urandom_range(0, 3)));
        end

        repeat (3) @(negedge i_clk);
        chk("scoreboard_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/parity_accum.md
Name: parity_accum

Overview:
- Parametrised sequential successor to the 2-input XOR lab block: accumulates bitwise (column) XOR parity over a framed burst of WIDTH-bit words.
- Also produces the overall even-parity bit of the accumulated column vector.
- Sits between a word source (valid/ready) and a checker/display stage in the lab datapath.
- Frame length is programmable per burst up to MAX_WORDS.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- MAX_WORDS, 16, maximum words per frame (>=1).
- CW, $clog2(MAX_WORDS+1), derived localparam: width of LEN and of the word counter. Not overridable.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- START  input  1  frame start request, sampled in IDLE only.
- LEN  input  CW  number of words in the frame, sampled with START.
- D  input  WIDTH  data word.
- D_VALID  input  1  D holds a valid word.
- D_READY  output  1  block accepts D this cycle.
- P_COL  output  WIDTH  column XOR of all accepted words in the last frame.
- P_BIT  output  1  reduction XOR of P_COL.
- DONE  output  1  one-cycle pulse: P_COL/P_BIT are final.
- BUSY  output  1  high in ACCUM and DONE states.

Behaviour:
- Interface: one clock CLK; reset RST is asynchronous and active-high.
- Reset: state=IDLE; D_READY=0, P_COL=0, P_BIT=0, DONE=0, BUSY=0; counter=0. Takes effect immediately, including mid-frame. A partial frame is discarded with no DONE.
- States: IDLE(00), ACCUM(01), DONE(10). Encoding 11 is illegal and goes to IDLE on the next cycle.
- IDLE:
  - D_READY=0, BUSY=0.
  - START=1 with LEN!=0: clear accumulator, load counter=min(LEN,MAX_WORDS), go to ACCUM.
  - START=1 with LEN=0: accumulator cleared, go directly to DONE. The result is P_COL=0, P_BIT=0.
  - LEN>MAX_WORDS is clamped to MAX_WORDS.
- ACCUM:
  - D_READY=1 (combinational from state only, never from D_VALID).
  - Transfer occurs when D_VALID&D_READY: acc <= acc ^ D, counter decrements.
  - When a transfer occurs with counter==1, go to DONE.
  - D_VALID=0 stalls indefinitely with no state change.
- DONE:
  - Lasts exactly one cycle. DONE=1, D_READY=0; P_COL=acc and P_BIT=^acc are valid this cycle.
  - Next state is IDLE.
- Latency: DONE is asserted in the cycle after the last word is accepted. Throughput is one word per cycle in ACCUM.
- P_COL and P_BIT are registered. They update only on entry to DONE and hold until the next DONE or reset. They do not change during a subsequent frame.
- START outside IDLE is ignored; it is not queued.
- START asserted in the same cycle DONE is high is ignored. The earliest new frame starts with START sampled in IDLE, i.e. two cycles after the last transfer.
- No arithmetic other than XOR and counter decrement. The counter never underflows: it is only decremented on a transfer in ACCUM, where counter>=1.

Optional Feature:
- Macro: PARITY_CHECK_EN.
- Defined:
  - Adds input EXP_COL [WIDTH-1:0] and output P_ERR (1).
  - P_ERR is registered on entry to DONE as |(acc ^ EXP_COL); EXP_COL is sampled in the last-transfer cycle (LEN=0 frames: in the START cycle).
  - P_ERR holds like P_COL; reset value 0.
- Undefined: neither port exists; behaviour is otherwise identical.

Decomposition:
- Package parity_pkg:
  - state typedef with the IDLE/ACCUM/DONE encodings;
  - reset-value constants;
  - a clog2-based width helper for CW.
- One sub-module is natural: xor_word.
  - Purely combinational: WIDTH-bit bitwise XOR of two words, plus reduction XOR output.
  - Used for the accumulator update and for P_BIT.

Test Plan:
- Reset mid-frame: START, LEN=4, two words accepted, then RST pulse. Required: all outputs 0 immediately, no DONE, next frame unaffected.
- Basic frame: WIDTH=8, LEN=3, words 0xA5, 0x3C, 0x0F, back-to-back. Required: DONE one cycle after third transfer, P_COL=0x96, P_BIT=0.
- Stalls: LEN=2, D_VALID toggling 1,0,0,1 with words 0xFF, 0x01. Required: only two transfers counted, P_COL=0xFE, P_BIT=1, D_READY high throughout ACCUM.
- Boundaries:
  - LEN=0: DONE one cycle after START, P_COL=0.
  - LEN=31 with MAX_WORDS=16: exactly 16 words accepted, then DONE.
- START ignored: START held high throughout a LEN=2 frame. Required: exactly one frame; the new frame begins only from IDLE; P_COL holds its old value until the new DONE.
- PARITY_CHECK_EN: frame 0x12, 0x34 with EXP_COL=0x26 gives P_ERR=0; repeat with EXP_COL=0x27 gives P_ERR=1.
